mul_hilo_ctrl: RTL
==================

# mul_hilo_ctrl

Sequencing and result-holding stage directly downstream of the Booth multiplier (`MUL`). It accepts a multiply request from the execute stage, registers the operands that drive the multiplier, and waits a fixed number of cycles for the multiplier output to settle. It then captures the 64-bit product into the architectural HI/LO registers and interlocks `mfhi`/`mflo` reads until the result is available. It also services `mthi`/`mtlo` writes.

## Interface
- `WIDTH`, 32: operand and HI/LO width.
- `MUL_LATENCY`, 4: clock edges from operand launch to capture of the multiplier output. Legal range is 1–15.

Ports:
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: multiply request; sampled only in IDLE.
- `a_in`  in  WIDTH: signed multiplicand, valid with `start`.
- `b_in`  in  WIDTH: signed multiplier, valid with `start`.
- `mul_a`  out  WIDTH: registered operand driving the multiplier's `a` input.
- `mul_b`  out  WIDTH: registered operand driving the multiplier's `b` input.
- `mul_hi`  in  WIDTH: multiplier `cHI`, the upper half of the product.
- `mul_lo`  in  WIDTH: multiplier `cLOW`, the lower half of the product.
- `mthi`  in  1: write `wdata` to HI.
- `mtlo`  in  1: write `wdata` to LO.
- `wdata`  in  WIDTH: data for `mthi`/`mtlo`.
- `rd_req`  in  1: the execute stage is issuing `mfhi`/`mflo` this cycle.
- `busy`  out  1: a multiply is in flight.
- `done`  out  1: one-cycle pulse; HI/LO were updated by a multiply on the previous edge.
- `stall`  out  1: `rd_req & busy`, combinational.
- `hi`  out  WIDTH: architectural HI register.
- `lo`  out  WIDTH: architectural LO register.

## Operation
- Two-state FSM: IDLE and RUN.
- Down-counter `cnt` is `$clog2(MUL_LATENCY)+1` bits wide.
- Reset values: state IDLE, `cnt` 0, `mul_a`/`mul_b` 0, `hi`/`lo` 0, `done` 0, `busy` 0, `stall` 0.
- **IDLE, `start`=1:**
  - `mul_a`←`a_in`, `mul_b`←`b_in`, `cnt`←`MUL_LATENCY-1`.
  - Next state RUN.
- **IDLE, `start`=0:** hold state and operands.
- **RUN, `cnt`≠0:** `cnt`←`cnt-1`.
- **RUN, `cnt`=0:**
  - `hi`←`mul_hi`, `lo`←`mul_lo`, `done`←1.
  - Next state IDLE.
- `done` is 0 on every edge except the one above.
- `busy` = (state==RUN), a registered decode.
- `mul_a`/`mul_b` stay stable for the whole RUN period; the combinational multiplier therefore has `MUL_LATENCY` full cycles to settle.
- The product is treated as a signed 64-bit value split into HI/LO exactly as delivered. This block performs no arithmetic.
- **`mthi`/`mtlo`:**
  - In IDLE, write `wdata` into HI/LO on the edge.
  - In RUN, the write is dropped. HI/LO are owned by the pending multiply.
- **Simultaneous events:**
  - `start` plus `mthi`/`mtlo` in IDLE: the move-write takes effect on that edge, and the multiply overwrites it `MUL_LATENCY` edges later.
  - `mthi` and `mtlo` together: both registers are written with `wdata`.
  - `start` while `busy`: ignored, with no queueing. The upstream stage must hold `start` until it observes `busy`=0.
  - `start` in the cycle `done`=1: accepted, since the FSM is already in IDLE. This gives back-to-back multiplies with no bubble.
- `rd_req` while `busy`: `stall`=1 for every such cycle. `hi`/`lo` outputs always show committed values and are never partial.
- **Reset mid-operation:** the FSM returns to IDLE immediately (asynchronously), `hi`/`lo` clear to 0, and no capture occurs.

## Timing
- Start-accept edge E0: `busy` rises after E0.
- Capture edge is E0+`MUL_LATENCY`; `hi`/`lo` are valid after it, with `done`=1 in that same cycle.
- `busy` is high for exactly `MUL_LATENCY` cycles.
- `stall` has zero-cycle latency from `rd_req`/`busy`.
- Minimum issue interval between multiplies is `MUL_LATENCY` cycles.
- `mthi`/`mtlo` in IDLE take effect after a single edge.

## Test plan
- Reset, then `start` with a=7, b=−3 (0xFFFFFFFD), `MUL_LATENCY`=4 → `busy` high for 4 cycles; after edge 4, HI=0xFFFFFFFF, LO=0xFFFFFFEB, `done` pulses once.
- a=0x7FFFFFFF, b=0x7FFFFFFF → HI=0x3FFFFFFF, LO=0x00000001. A second `start` with a=−1, b=−1 is issued in the `done` cycle → HI=0, LO=1 exactly 4 edges later.
- `rd_req` held high from the start edge onward → `stall`=1 for exactly 4 cycles, 0 once `done` is seen.
- `mthi` with `wdata`=0xA5A5A5A5 in IDLE → HI=0xA5A5A5A5 next cycle. `mtlo` with 0x12345678 during RUN → dropped; LO equals the product.
- `start` asserted again mid-RUN with different operands → ignored; `mul_a`/`mul_b` unchanged and the original product is captured.
- `reset_n` pulled low at cycle 2 of RUN → `busy`, `hi`, `lo`, `done` all 0 immediately; no capture after release.

Source files
------------

// File: rtl/mul_hilo_ctrl.sv
// mul_hilo_ctrl: sequences a multi-cycle settle of the downstream Booth
// multiplier and owns the architectural HI/LO registers. It also handles
// mthi/mtlo writes and interlocks mfhi/mflo reads while a multiply is in flight.
module mul_hilo_ctrl #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    input  logic [WIDTH-1:0] mul_hi,
    input  logic [WIDTH-1:0] mul_lo,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_req,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(MUL_LATENCY) + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    // Reads of HI/LO must wait while a multiply owns them.
    assign stall = rd_req & busy;

    // Control FSM. Operands are latched once at accept and then held for the
    // whole RUN period, so the combinational multiplier sees stable inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            mul_a <= '0;
            mul_b <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // Move-writes land even when a multiply starts on the same
                    // edge; the capture later overwrites them.
                    if (mthi) hi <= wdata;
                    if (mtlo) lo <= wdata;
                    if (start) begin
                        mul_a <= a_in;
                        mul_b <= b_in;
                        cnt   <= CW'(MUL_LATENCY - 1);
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    // start, mthi and mtlo are dropped here.
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        hi    <= mul_hi;
                        lo    <= mul_lo;
                        done  <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
